// File: rtl/ldm_stm_pkg.sv
// Shared types and helpers for the LDM/STM block-transfer sequencer.
package ldm_stm_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      WB   = 2'd2,
      DONE = 2'd3
   } state_e;

   localparam int         WORD_BYTES = 4;
   localparam logic [3:0] R15        = 4'd15;

   function automatic logic [4:0] popcount16(input logic [15:0] v);
      logic [4:0] c;
      c = '0;
      for (int i = 0; i < 16; i++) c = c + 5'(v[i]);
      return c;
   endfunction

endpackage

// File: rtl/ldm_stm_seq_prio_enc16.sv
// Lowest-set-bit priority encoder: picks the next register of the remaining list.
module prio_enc16 (
   input  logic [15:0] vec_i,
   output logic [3:0]  idx_o,
   output logic        valid_o
);

   always_comb begin
      idx_o   = '0;
      valid_o = |vec_i;
      // Scan high to low so the last hit, i.e. the lowest set bit, wins.
      for (int i = 15; i >= 0; i--) begin
         if (vec_i[i]) idx_o = 4'(i);
      end
   end

endmodule

// File: rtl/ldm_stm_seq.sv
// LDM/STM sequencer: one req/ack memory beat per listed register, then optional base writeback.
// Define LDM_STM_ABORT_EN to add the mem_abort input and aborted output.
module ldm_stm_seq
   import ldm_stm_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              load,
   input  logic              pre,
   input  logic              up,
   input  logic              wback,
   input  logic [3:0]        base_reg,
   input  logic [ADDR_W-1:0] base,
   input  logic [15:0]       reg_list,
   output logic              busy,
   output logic              done,
   output logic [3:0]        rf_ra,
   input  logic [DATA_W-1:0] rf_rd,
   output logic              rf_we,
   output logic [3:0]        rf_wa,
   output logic [DATA_W-1:0] rf_wd,
   output logic              pc_load,
   output logic [DATA_W-1:0] pc_wdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata
`ifdef LDM_STM_ABORT_EN
   ,
   input  logic              mem_abort,
   output logic              aborted
`endif
);

   state_e            state_q, state_d;
   logic [15:0]       list_q, list_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] final_base_q, final_base_d;
   logic [3:0]        base_reg_q, base_reg_d;
   logic              load_q, load_d;
   logic              wb_en_q, wb_en_d;
`ifdef LDM_STM_ABORT_EN
   logic              aborted_q, aborted_d;
`endif

   logic [3:0]        cur_idx;
   logic              cur_valid;
   logic [ADDR_W-1:0] span;
   logic [ADDR_W-1:0] start_addr;

   prio_enc16 u_prio (
      .vec_i   (list_q),
      .idx_o   (cur_idx),
      .valid_o (cur_valid)
   );

   assign span = ADDR_W'(popcount16(reg_list)) * ADDR_W'(WORD_BYTES);

   // Lowest register always sits at the lowest address; P/U only move the window.
   always_comb begin
      unique case ({pre, up})
         2'b01:   start_addr = base;
         2'b11:   start_addr = base + ADDR_W'(WORD_BYTES);
         2'b00:   start_addr = base - span + ADDR_W'(WORD_BYTES);
         default: start_addr = base - span;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         list_q       <= '0;
         addr_q       <= '0;
         final_base_q <= '0;
         base_reg_q   <= '0;
         load_q       <= 1'b0;
         wb_en_q      <= 1'b0;
`ifdef LDM_STM_ABORT_EN
         aborted_q    <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         list_q       <= list_d;
         addr_q       <= addr_d;
         final_base_q <= final_base_d;
         base_reg_q   <= base_reg_d;
         load_q       <= load_d;
         wb_en_q      <= wb_en_d;
`ifdef LDM_STM_ABORT_EN
         aborted_q    <= aborted_d;
`endif
      end
   end

   // NOTE: every output and next-state value gets a default first so no latch is inferred.
   always_comb begin
      state_d      = state_q;
      list_d       = list_q;
      addr_d       = addr_q;
      final_base_d = final_base_q;
      base_reg_d   = base_reg_q;
      load_d       = load_q;
      wb_en_d      = wb_en_q;
`ifdef LDM_STM_ABORT_EN
      aborted_d    = aborted_q;
      aborted      = 1'b0;
`endif
      busy      = (state_q != IDLE);
      done      = 1'b0;
      rf_ra     = '0;
      rf_we     = 1'b0;
      rf_wa     = '0;
      rf_wd     = '0;
      pc_load   = 1'b0;
      pc_wdata  = '0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               load_d       = load;
               base_reg_d   = base_reg;
               list_d       = reg_list;
               addr_d       = start_addr;
               final_base_d = up ? base + span : base - span;
               // A loaded base register overrides the writeback.
               wb_en_d      = wback & ~(load & reg_list[base_reg]);
`ifdef LDM_STM_ABORT_EN
               aborted_d    = 1'b0;
`endif
               state_d      = (reg_list == '0) ? DONE : XFER;
            end
         end

         XFER: begin
            mem_req  = cur_valid;
            mem_we   = ~load_q;
            mem_addr = addr_q;
            if (!load_q) begin
               rf_ra     = cur_idx;
               mem_wdata = rf_rd;
            end
`ifdef LDM_STM_ABORT_EN
            if (mem_abort) begin
               list_d    = '0;
               aborted_d = 1'b1;
               state_d   = DONE;
            end else
`endif
            if (mem_ack) begin
               if (load_q) begin
                  if (cur_idx == R15) begin
                     pc_load  = 1'b1;
                     pc_wdata = mem_rdata;
                  end else begin
                     rf_we = 1'b1;
                     rf_wa = cur_idx;
                     rf_wd = mem_rdata;
                  end
               end
               list_d = list_q & ~(16'd1 << cur_idx);
               addr_d = addr_q + ADDR_W'(WORD_BYTES);
               if (list_d == '0) state_d = wb_en_q ? WB : DONE;
            end
         end

         WB: begin
            rf_we   = 1'b1;
            rf_wa   = base_reg_q;
            rf_wd   = DATA_W'(final_base_q);
            state_d = DONE;
         end

         DONE: begin
            done    = 1'b1;
`ifdef LDM_STM_ABORT_EN
            aborted = aborted_q;
`endif
            state_d = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_ldm_stm_seq.sv
// Randomized bench for ldm_stm_seq against a transfer-list reference model and a behavioural register file.
module tb_ldm_stm_seq;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start, load, pre, up, wback;
   logic [3:0]  base_reg;
   logic [31:0] base;
   logic [15:0] reg_list;
   logic        busy, done;
   logic [3:0]  rf_ra, rf_wa;
   logic [31:0] rf_rd, rf_wd, pc_wdata;
   logic        rf_we, pc_load;
   logic        mem_req, mem_we, mem_ack;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   int n_total = 0;
   int n_bad   = 0;

   logic [31:0] rf_mem [16];
   logic [31:0] pc_q;
   logic [31:0] exp_rf [16];
   logic [31:0] exp_pc;
   logic        load_rf = 1'b0;

   always #5 clk = ~clk;

   ldm_stm_seq #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .load      (load),
      .pre       (pre),
      .up        (up),
      .wback     (wback),
      .base_reg  (base_reg),
      .base      (base),
      .reg_list  (reg_list),
      .busy      (busy),
      .done      (done),
      .rf_ra     (rf_ra),
      .rf_rd     (rf_rd),
      .rf_we     (rf_we),
      .rf_wa     (rf_wa),
      .rf_wd     (rf_wd),
      .pc_load   (pc_load),
      .pc_wdata  (pc_wdata),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata)
   );

   // Behavioural register file: R15 reads as PC+8.
   assign rf_rd = (rf_ra == 4'd15) ? pc_q + 32'd8 : rf_mem[rf_ra];

   always @(posedge clk) begin
      if (load_rf) begin
         for (int i = 0; i < 16; i++) rf_mem[i] <= exp_rf[i];
         pc_q <= exp_pc;
      end else begin
         if (rf_we)   rf_mem[rf_wa] <= rf_wd;
         if (pc_load) pc_q          <= pc_wdata;
      end
   end

   function automatic logic [31:0] memval(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_ctl"}, {busy, done, mem_req, mem_we, rf_we, pc_load}, 0);
      check({tag, "_addr"}, {mem_addr, rf_ra, rf_wa}, 0);
      check({tag, "_data"}, {mem_wdata, rf_wd, pc_wdata}, 0);
   endtask

   task automatic check_rf(input string tag);
      for (int i = 0; i < 16; i++) check({tag, "_rf"}, rf_mem[i], exp_rf[i]);
      check({tag, "_pc"}, pc_q, exp_pc);
   endtask

   task automatic sync_rf();
      load_rf = 1'b1;
      @(posedge clk);
      #1 load_rf = 1'b0;
   endtask

   // dly < 0 picks a random 0..3 ack delay per beat; rst_after > 0 resets after that many acks.
   task automatic run_op(input logic ld, input logic p, input logic u, input logic w,
                         input logic [3:0] br, input logic [31:0] b, input logic [15:0] lst,
                         input int dly, input int rst_after);
      int          regs[$];
      int          n, cyc, total_dly, d;
      logic [31:0] addr, span, final_b;
      logic        wb_exp, ack_now;
      logic [3:0]  r;

      exp_rf[br] = b;
      sync_rf();

      regs = {};
      for (int i = 0; i < 16; i++) if (lst[i]) regs.push_back(i);
      n       = regs.size();
      span    = 32'(4 * n);
      addr    = u ? (p ? b + 32'd4 : b) : (p ? b - span : b - span + 32'd4);
      final_b = u ? b + span : b - span;
      wb_exp  = w && (n != 0) && !(ld && lst[br]);

      start = 1'b1; load = ld; pre = p; up = u; wback = w;
      base_reg = br; base = b; reg_list = lst;
      @(posedge clk);
      #1;
      start = 1'b0; base = $urandom; reg_list = 16'($urandom);
      cyc = 1;
      total_dly = 0;

      for (int k = 0; k < n; k++) begin
         r = 4'(regs[k]);
         d = (dly < 0) ? int'($urandom_range(0, 3)) : dly;
         total_dly += d;
         for (int wv = 0; wv <= d; wv++) begin
            ack_now   = (wv == d);
            mem_ack   = ack_now;
            mem_rdata = ack_now ? memval(addr) : 32'($urandom);
            #1;
            check("busy_xfer", busy, 1);
            check("done_xfer", done, 0);
            check("mem_req", mem_req, 1);
            check("mem_addr", mem_addr, addr);
            check("mem_we", mem_we, !ld);
            if (!ld) check("mem_wdata", mem_wdata, (r == 4'd15) ? exp_pc + 32'd8 : exp_rf[r]);
            check("rf_we", rf_we, ack_now && ld && (r != 4'd15));
            if (ack_now && ld && (r != 4'd15)) begin
               check("rf_wa", rf_wa, r);
               check("rf_wd", rf_wd, memval(addr));
            end
            check("pc_load", pc_load, ack_now && ld && (r == 4'd15));
            if (ack_now && ld && (r == 4'd15)) check("pc_wdata", pc_wdata, memval(addr));
            @(posedge clk);
            #1;
            cyc++;
         end
         mem_ack = 1'b0;
         if (ld) begin
            if (r == 4'd15) exp_pc = memval(addr);
            else            exp_rf[r] = memval(addr);
         end
         addr += 32'd4;
         if (rst_after == k + 1) begin
            reset_n = 1'b0;
            #1;
            check_idle_outputs("reset_mid");
            repeat (2) @(posedge clk);
            #1 reset_n = 1'b1;
            @(posedge clk);
            #1;
            check("busy_after_reset", busy, 0);
            check("req_after_reset", mem_req, 0);
            check_rf("reset_mid");
            return;
         end
      end

      mem_ack = 1'b0;
      #1;
      if (wb_exp) begin
         check("wb_rf_we", rf_we, 1);
         check("wb_rf_wa", rf_wa, br);
         check("wb_rf_wd", rf_wd, final_b);
         check("wb_mem_req", mem_req, 0);
         check("wb_done", done, 0);
         exp_rf[br] = final_b;
         @(posedge clk);
         #1;
         cyc++;
         #1;
      end

      check("done", done, 1);
      check("busy_done", busy, 1);
      check("done_req", {mem_req, rf_we, pc_load}, 0);
      check("latency", cyc, n + total_dly + (wb_exp ? 1 : 0) + 1);

      // A start in the DONE cycle must be ignored.
      start = 1'b1; reg_list = 16'hFFFF; load = 1'($urandom);
      @(posedge clk);
      #1 start = 1'b0;
      #1;
      check("idle_busy", busy, 0);
      check("idle_ctl", {done, mem_req, rf_we}, 0);
      check_rf("op_end");
   endtask

   initial begin
      reset_n = 1'b0;
      start = 1'b0; load = 1'b0; pre = 1'b0; up = 1'b0; wback = 1'b0;
      base_reg = '0; base = '0; reg_list = '0;
      mem_ack = 1'b0; mem_rdata = '0;
      for (int i = 0; i < 16; i++) exp_rf[i] = $urandom;
      exp_pc = 32'h0000_8000;

      #12;
      check_idle_outputs("reset");
      @(posedge clk);
      #1 reset_n = 1'b1;

      // STM IA with writeback, ack every cycle.
      run_op(1'b0, 1'b0, 1'b1, 1'b1, 4'd13, 32'h100, 16'h0013, 0, 0);
      // LDM DB with writeback, R15 in the list.
      run_op(1'b1, 1'b1, 1'b0, 1'b1, 4'd13, 32'h200, 16'h8006, 0, 0);
      // Slow memory on every beat.
      run_op(1'b0, 1'b1, 1'b1, 1'b0, 4'd2, 32'h340, 16'h0421, 3, 0);
      run_op(1'b1, 1'b0, 1'b0, 1'b1, 4'd5, 32'h480, 16'h1208, 3, 0);
      // Empty list.
      run_op(1'b0, 1'b0, 1'b1, 1'b1, 4'd3, 32'h600, 16'h0000, 0, 0);
      // LDM loading its own base register: no writeback.
      run_op(1'b1, 1'b0, 1'b1, 1'b1, 4'd13, 32'h700, 16'h2001, 1, 0);
      // STM storing its own base register.
      run_op(1'b0, 1'b0, 1'b0, 1'b1, 4'd4, 32'h800, 16'h8030, -1, 0);
      // Reset after the second ack of a 4-beat STM, then a clean run.
      run_op(1'b0, 1'b0, 1'b1, 1'b1, 4'd9, 32'h900, 16'h00F0, 0, 2);
      run_op(1'b1, 1'b1, 1'b1, 1'b1, 4'd9, 32'hA00, 16'h00F0, -1, 0);

      for (int t = 0; t < 40; t++) begin
         logic [15:0] lst;
         lst = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
         run_op(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                4'($urandom_range(0, 14)), 32'($urandom) & ~32'h3, lst, -1, 0);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
